m_mem_arb: RTL

- Single-port memory arbiter for the 5-stage pipeline.
- Shares one fixed-latency, single-ported unified memory between the instruction-fetch (IF) requester and the data-memory (MEM-stage) requester.
- Sequences each access, latches the returned data, and produces per-port acks and stall signals that freeze the pipeline while a port waits.
- MEM has priority, with a starvation guard so IF always progresses.

---
 rtl/m_mem_arb_pkg.sv | 24 ++
 rtl/m_mem_arb.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/m_mem_arb_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// m_mem_arb_pkg : FSM/owner encodings and sizing helper for m_mem_arb
// Rev 1.0
// ------------------------------------------------------------------
package m_mem_arb_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   // Bits needed to hold the values 0..max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/m_mem_arb.sv
`default_nettype none
// ------------------------------------------------------------------
// m_mem_arb : single-port memory arbiter, DM priority with IF starvation guard
// Rev 1.0
// ------------------------------------------------------------------
module m_mem_arb
   import m_mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LAT    = 2,
   parameter int STARVE = 4
) (
   input  logic                w_clk,
   input  logic                w_rst,
   input  logic                w_if_req,
   input  logic [ADDR_W-1:0]   w_if_addr,
   output logic                r_if_ack,
   output logic [DATA_W-1:0]   r_if_rdata,
   input  logic                w_dm_req,
   input  logic                w_dm_we,
   input  logic [ADDR_W-1:0]   w_dm_addr,
   input  logic [DATA_W-1:0]   w_dm_wdata,
   input  logic [DATA_W/8-1:0] w_dm_be,
   output logic                r_dm_ack,
   output logic [DATA_W-1:0]   r_dm_rdata,
   output logic                w_stall_if,
   output logic                w_stall_dm,
   output logic                r_mem_req,
   output logic                r_mem_we,
   output logic [ADDR_W-1:0]   r_mem_addr,
   output logic [DATA_W-1:0]   r_mem_wdata,
   output logic [DATA_W/8-1:0] r_mem_be,
   input  logic [DATA_W-1:0]   w_mem_rdata
);

   localparam int c_lat_w = cnt_width(LAT);
   localparam int c_stv_w = cnt_width(STARVE);
   localparam logic [c_lat_w-1:0] c_lat    = c_lat_w'(LAT);
   localparam logic [c_stv_w-1:0] c_starve = c_stv_w'(STARVE);

   state_t               r_state,      w_state_nxt;
   owner_t               r_owner,      w_owner_nxt;
   logic [c_lat_w-1:0]   r_lat_cnt,    w_lat_cnt_nxt;
   logic [c_stv_w-1:0]   r_starve_cnt, w_starve_cnt_nxt;
   logic                 w_if_ack_nxt, w_dm_ack_nxt, w_mem_req_nxt, w_mem_we_nxt;
   logic [DATA_W-1:0]    w_if_rdata_nxt, w_dm_rdata_nxt, w_mem_wdata_nxt;
   logic [ADDR_W-1:0]    w_mem_addr_nxt;
   logic [DATA_W/8-1:0]  w_mem_be_nxt;
   logic                 w_grant_dm, w_grant_if;

   // The stall terms double as the effective requests: a port being acked
   // this cycle still holds req high but must not be granted again.
   assign w_stall_if = w_if_req & ~r_if_ack;
   assign w_stall_dm = w_dm_req & ~r_dm_ack;

   assign w_grant_dm = w_stall_dm & (~w_stall_if | (r_starve_cnt < c_starve));
   assign w_grant_if = ~w_grant_dm & w_stall_if;

   always_comb begin
      w_state_nxt      = r_state;
      w_owner_nxt      = r_owner;
      w_lat_cnt_nxt    = r_lat_cnt;
      w_starve_cnt_nxt = r_starve_cnt;
      w_if_ack_nxt     = 1'b0;
      w_dm_ack_nxt     = 1'b0;
      w_mem_req_nxt    = 1'b0;
      w_mem_we_nxt     = r_mem_we;
      w_mem_addr_nxt   = r_mem_addr;
      w_mem_wdata_nxt  = r_mem_wdata;
      w_mem_be_nxt     = r_mem_be;
      w_if_rdata_nxt   = r_if_rdata;
      w_dm_rdata_nxt   = r_dm_rdata;

      case (r_state)
         S_IDLE: begin
            if (w_grant_dm) begin
               w_state_nxt     = S_BUSY;
               w_owner_nxt     = OWN_DM;
               w_lat_cnt_nxt   = c_lat_w'(1);
               w_mem_req_nxt   = 1'b1;
               w_mem_we_nxt    = w_dm_we;
               w_mem_addr_nxt  = w_dm_addr;
               w_mem_wdata_nxt = w_dm_wdata;
               w_mem_be_nxt    = w_dm_be;
               if (!w_stall_if)
                  w_starve_cnt_nxt = '0;
               else if (r_starve_cnt < c_starve)
                  w_starve_cnt_nxt = r_starve_cnt + 1'b1;
            end else if (w_grant_if) begin
               w_state_nxt      = S_BUSY;
               w_owner_nxt      = OWN_IF;
               w_lat_cnt_nxt    = c_lat_w'(1);
               w_mem_req_nxt    = 1'b1;
               w_mem_we_nxt     = 1'b0;
               w_mem_addr_nxt   = w_if_addr;
               w_mem_be_nxt     = '0;
               w_starve_cnt_nxt = '0;
            end
         end
         S_BUSY: begin
            // The strobe cycle itself does not advance the count, so the
            // capture lands exactly LAT cycles after the strobe.
            if (!r_mem_req) begin
               if (r_lat_cnt < c_lat) begin
                  w_lat_cnt_nxt = r_lat_cnt + 1'b1;
               end else begin
                  w_state_nxt   = S_IDLE;
                  w_lat_cnt_nxt = '0;
                  if (r_owner == OWN_IF) begin
                     w_if_ack_nxt   = 1'b1;
                     w_if_rdata_nxt = w_mem_rdata;
                  end else begin
                     w_dm_ack_nxt = 1'b1;
                     if (!r_mem_we)
                        w_dm_rdata_nxt = w_mem_rdata;
                  end
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_state      <= S_IDLE;
         r_owner      <= OWN_IF;
         r_lat_cnt    <= '0;
         r_starve_cnt <= '0;
         r_if_ack     <= 1'b0;
         r_dm_ack     <= 1'b0;
         r_if_rdata   <= '0;
         r_dm_rdata   <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_mem_be     <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_lat_cnt    <= w_lat_cnt_nxt;
         r_starve_cnt <= w_starve_cnt_nxt;
         r_if_ack     <= w_if_ack_nxt;
         r_dm_ack     <= w_dm_ack_nxt;
         r_if_rdata   <= w_if_rdata_nxt;
         r_dm_rdata   <= w_dm_rdata_nxt;
         r_mem_req    <= w_mem_req_nxt;
         r_mem_we     <= w_mem_we_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_mem_wdata  <= w_mem_wdata_nxt;
         r_mem_be     <= w_mem_be_nxt;
      end
   end

endmodule
`default_nettype wire
